// File: rtl/alu_pkg.sv
// Shared definitions for the ALU and its request arbiter: op codes,
// arbiter FSM encoding and op legality.
package alu_pkg;

    localparam logic [3:0] OP_AND = 4'd0;
    localparam logic [3:0] OP_OR  = 4'd1;
    localparam logic [3:0] OP_XOR = 4'd2;
    localparam logic [3:0] OP_NOR = 4'd3;
    localparam logic [3:0] OP_ADD = 4'd5;
    localparam logic [3:0] OP_SUB = 4'd6;
    localparam logic [3:0] OP_SLT = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8;
    localparam logic [3:0] OP_SLL = 4'd9;
    localparam logic [3:0] OP_SRA = 4'd10;
    localparam logic [3:0] OP_MAX = 4'd10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_e;

    // Code 4 is a hole in the op map; everything above OP_MAX is unused.
    function automatic logic is_legal_op(input logic [3:0] op);
        return (op <= OP_MAX) && (op != 4'd4);
    endfunction

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU: logic ops, add/sub with signed overflow,
// signed set-less-than and shifts by Y[4:0].
module alu
    import alu_pkg::*;
(
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic [3:0]  op_code,
    output logic [31:0] z,
    output logic        overflow,
    output logic        equal,
    output logic        zero
);

    logic [31:0] sum;
    logic [31:0] diff;

    assign sum  = x + y;
    assign diff = x - y;

    always_comb begin
        z        = '0;
        overflow = 1'b0;
        case (op_code)
            OP_AND: z = x & y;
            OP_OR:  z = x | y;
            OP_XOR: z = x ^ y;
            OP_NOR: z = ~(x | y);
            OP_ADD: begin
                z        = sum;
                overflow = (x[31] == y[31]) && (sum[31] != x[31]);
            end
            OP_SUB: begin
                z        = diff;
                overflow = (x[31] != y[31]) && (diff[31] != x[31]);
            end
            OP_SLT: z = {31'b0, $signed(x) < $signed(y)};
            OP_SRL: z = x >> y[4:0];
            OP_SLL: z = x << y[4:0];
            OP_SRA: z = $unsigned($signed(x) >>> y[4:0]);
            default: z = '0;
        endcase
    end

    assign equal = (x == y);
    assign zero  = (z == '0);

endmodule

// File: rtl/alu_arbiter_rr_picker.sv
// Round-robin picker: first valid requester at or after rr_ptr, wrapping
// modulo N_REQ. Returns the one-hot grant and its index.
module rr_picker #(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] valid,
    input  logic [ID_W-1:0]  rr_ptr,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  grant_idx,
    output logic             any_valid
);

    int              pos;
    logic [ID_W-1:0] sel;

    // Scan from the farthest offset down so the closest valid one wins.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        pos       = 0;
        sel       = '0;
        any_valid = |valid;
        for (int off = N_REQ - 1; off >= 0; off--) begin
            pos = int'(rr_ptr) + off;
            if (pos >= N_REQ) pos = pos - N_REQ;
            sel = pos[ID_W-1:0];
            if (valid[sel]) begin
                grant      = '0;
                grant[sel] = 1'b1;
                grant_idx  = sel;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between N_REQ requesters: round-robin request grant,
// registered operands, one EXEC cycle, then a valid/ready response.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int ID_W  = $clog2(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [32*N_REQ-1:0] req_x,
    input  logic [32*N_REQ-1:0] req_y,
    input  logic [4*N_REQ-1:0] req_op,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic [ID_W-1:0]    rsp_id,
    output logic [31:0]        rsp_z,
    output logic               rsp_overflow,
    output logic               rsp_equal,
    output logic               rsp_zero,
    output logic               rsp_err,
    output logic               busy
);

    // Handshakes: a request transfers on an edge where req_valid[i] and
    // req_ready[i] are both 1; a response transfers where rsp_valid and
    // rsp_ready are both 1. Requesters hold valid and operands until ready.

    state_e            state_q, state_d;
    logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [31:0]       op_x_q, op_x_d, op_y_q, op_y_d;
    logic [3:0]        op_code_q, op_code_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
    logic [31:0]       rsp_z_q, rsp_z_d;
    logic              rsp_ovf_q, rsp_ovf_d, rsp_eq_q, rsp_eq_d;
    logic              rsp_zero_q, rsp_zero_d, rsp_err_q, rsp_err_d;

    logic [31:0]       x_arr [N_REQ];
    logic [31:0]       y_arr [N_REQ];
    logic [3:0]        op_arr [N_REQ];
    logic [N_REQ-1:0]  grant;
    logic [ID_W-1:0]   grant_idx;
    logic              any_valid;
    logic              req_hs;
    logic              op_legal;
    logic [31:0]       alu_z;
    logic              alu_ovf, alu_eq, alu_zero;

    for (genvar i = 0; i < N_REQ; i++) begin : g_slice
        assign x_arr[i]  = req_x[32*i +: 32];
        assign y_arr[i]  = req_y[32*i +: 32];
        assign op_arr[i] = req_op[4*i +: 4];
    end

    rr_picker #(.N_REQ(N_REQ)) u_picker (
        .valid     (req_valid),
        .rr_ptr    (rr_ptr_q),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_valid (any_valid)
    );

    alu u_alu (
        .x        (op_x_q),
        .y        (op_y_q),
        .op_code  (op_code_q),
        .z        (alu_z),
        .overflow (alu_ovf),
        .equal    (alu_eq),
        .zero     (alu_zero)
    );

    assign req_hs   = |(req_valid & req_ready);
    assign op_legal = is_legal_op(op_code_q);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            op_x_q      <= '0;
            op_y_q      <= '0;
            op_code_q   <= '0;
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_z_q     <= '0;
            rsp_ovf_q   <= 1'b0;
            rsp_eq_q    <= 1'b0;
            rsp_zero_q  <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            op_x_q      <= op_x_d;
            op_y_q      <= op_y_d;
            op_code_q   <= op_code_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_z_q     <= rsp_z_d;
            rsp_ovf_q   <= rsp_ovf_d;
            rsp_eq_q    <= rsp_eq_d;
            rsp_zero_q  <= rsp_zero_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_hs) state_d = EXEC;
            EXEC:    state_d = RESP;
            RESP:    if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        req_ready = (state_q == IDLE && rst_n) ? grant : '0;
        busy      = (state_q != IDLE);
    end

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        op_x_d      = op_x_q;
        op_y_d      = op_y_q;
        op_code_d   = op_code_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_z_d     = rsp_z_q;
        rsp_ovf_d   = rsp_ovf_q;
        rsp_eq_d    = rsp_eq_q;
        rsp_zero_d  = rsp_zero_q;
        rsp_err_d   = rsp_err_q;
        case (state_q)
            IDLE: if (req_hs) begin
                op_x_d    = x_arr[grant_idx];
                op_y_d    = y_arr[grant_idx];
                op_code_d = op_arr[grant_idx];
                rsp_id_d  = grant_idx;
                rr_ptr_d  = (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
            end
            // Illegal ops report only rsp_err; result and flags read as zero.
            EXEC: begin
                rsp_valid_d = 1'b1;
                rsp_err_d   = !op_legal;
                rsp_z_d     = op_legal ? alu_z : '0;
                rsp_ovf_d   = op_legal && alu_ovf;
                rsp_eq_d    = op_legal && alu_eq;
                rsp_zero_d  = op_legal && alu_zero;
            end
            RESP: if (rsp_ready) begin
                rsp_valid_d = 1'b0;
                rsp_err_d   = 1'b0;
            end
            default: ;
        endcase
    end

    assign rsp_valid    = rsp_valid_q;
    assign rsp_id       = rsp_id_q;
    assign rsp_z        = rsp_z_q;
    assign rsp_overflow = rsp_ovf_q;
    assign rsp_equal    = rsp_eq_q;
    assign rsp_zero     = rsp_zero_q;
    assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: reset, latency, round-robin order,
// backpressure, illegal ops and abort by reset.
module tb_alu_arbiter;

    localparam int N_REQ = 4;
    localparam int ID_W  = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [N_REQ-1:0]  req_valid;
    logic [N_REQ-1:0]  req_ready;
    logic [32*N_REQ-1:0] req_x;
    logic [32*N_REQ-1:0] req_y;
    logic [4*N_REQ-1:0] req_op;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [ID_W-1:0]   rsp_id;
    logic [31:0]       rsp_z;
    logic              rsp_overflow, rsp_equal, rsp_zero, rsp_err;
    logic              busy;

    int n_cmp = 0;
    int n_err = 0;
    logic [31:0] exp_q[$];
    int          exp_id_q[$];

    alu_arbiter #(.N_REQ(N_REQ)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_x        (req_x),
        .req_y        (req_y),
        .req_op       (req_op),
        .rsp_valid    (rsp_valid),
        .rsp_ready    (rsp_ready),
        .rsp_id       (rsp_id),
        .rsp_z        (rsp_z),
        .rsp_overflow (rsp_overflow),
        .rsp_equal    (rsp_equal),
        .rsp_zero     (rsp_zero),
        .rsp_err      (rsp_err),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic set_slice(input int id, input logic [31:0] x, input logic [31:0] y,
                             input logic [3:0] op);
        req_x[32*id +: 32] = x;
        req_y[32*id +: 32] = y;
        req_op[4*id +: 4]  = op;
    endtask

    // Raise one request and return 1 time unit after its handshake edge.
    task automatic send(input int id, input logic [31:0] x, input logic [31:0] y,
                        input logic [3:0] op);
        int n;
        set_slice(id, x, y, op);
        req_valid[id] = 1'b1;
        #1;
        n = 0;
        while (!req_ready[id] && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready[id]) check("send_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        req_valid[id] = 1'b0;
    endtask

    task automatic expect_rsp(input string tag, input int id, input logic [31:0] z,
                              input logic ovf, input logic eq, input logic zr,
                              input logic er);
        int n;
        n = 0;
        @(negedge clk);
        while (!rsp_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
        check({tag, "_id"},    32'(rsp_id), 32'(id));
        check({tag, "_z"},     rsp_z, z);
        check({tag, "_ovf"},   32'(rsp_overflow), 32'(ovf));
        check({tag, "_eq"},    32'(rsp_equal), 32'(eq));
        check({tag, "_zero"},  32'(rsp_zero), 32'(zr));
        check({tag, "_err"},   32'(rsp_err), 32'(er));
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check({tag, "_done"}, 32'(rsp_valid), 32'd0);
    endtask

    // Directed vectors: requester, X, Y, op, expected Z/overflow/equal/zero/err.
    localparam int NV = 7;
    int          v_id  [NV] = '{0, 0, 2, 3, 1, 0, 2};
    logic [31:0] v_x   [NV] = '{32'd7, 32'd7, 32'h8000_0000, 32'h7FFF_FFFF,
                                32'hFFFF_0000, 32'd3, 32'h8000_0000};
    logic [31:0] v_y   [NV] = '{32'd9, 32'd9, 32'd4, 32'd1, 32'h0000_FFFF, 32'd3, 32'd31};
    logic [3:0]  v_op  [NV] = '{4'd11, 4'd7, 4'd10, 4'd5, 4'd3, 4'd4, 4'd8};
    logic [31:0] v_z   [NV] = '{32'd0, 32'd1, 32'hF800_0000, 32'h8000_0000,
                                32'd0, 32'd0, 32'd1};
    logic        v_ovf [NV] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    logic        v_eq  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    logic        v_zr  [NV] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        v_er  [NV] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    initial begin
        int grants [N_REQ];
        int n;
        int got_id;
        int seen;

        // Reset held 3 cycles with every requester asking.
        rst_n     = 1'b0;
        rsp_ready = 1'b0;
        req_x     = '0;
        req_y     = '0;
        req_op    = '0;
        req_valid = 4'b1111;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_busy",      32'(busy), 32'd0);
        check("rst_rsp_z",     rsp_z, 32'd0);
        check("rst_rsp_err",   32'(rsp_err), 32'd0);
        rst_n = 1'b1;
        #1;
        check("rst_first_grant", 32'(req_ready), 32'b0001);
        req_valid = '0;
        #1;
        check("idle_no_req", 32'(req_ready), 32'd0);
        @(negedge clk);

        // Single ADD from requester 2 with latency checks.
        send(2, 32'd1, 32'd2, 4'b0101);
        @(negedge clk);
        check("lat_exec_valid", 32'(rsp_valid), 32'd0);
        check("lat_exec_busy",  32'(busy), 32'd1);
        check("lat_exec_ready", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("lat_resp_valid", 32'(rsp_valid), 32'd1);
        expect_rsp("add", 2, 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);
        check("add_idle_busy", 32'(busy), 32'd0);

        // Fresh reset, then all four request continuously.
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < N_REQ; i++) begin
            set_slice(i, 32'(i + 10), 32'd1, 4'd5);
            grants[i] = 0;
        end
        req_valid = 4'b1111;
        rsp_ready = 1'b1;
        #1;
        for (int g = 0; g < 5; g++) begin
            n = 0;
            while (req_ready == '0 && n < 10) begin
                @(negedge clk);
                n++;
            end
            check("rr_grant", 32'(req_ready), 32'(4'b0001 << (g % N_REQ)));
            got_id = 0;
            for (int i = 0; i < N_REQ; i++) if (req_ready[i]) got_id = i;
            grants[got_id]++;
            exp_id_q.push_back(g % N_REQ);
            exp_q.push_back(32'((g % N_REQ) + 11));
            @(negedge clk);
            @(negedge clk);
            check("rr_rsp_valid", 32'(rsp_valid), 32'd1);
            check("rr_rsp_id", 32'(rsp_id), 32'(exp_id_q.pop_front()));
            check("rr_rsp_z", rsp_z, exp_q.pop_front());
            @(negedge clk);
        end
        req_valid = '0;
        rsp_ready = 1'b0;
        check("rr_count0", 32'(grants[0]), 32'd2);
        for (int i = 1; i < N_REQ; i++) check("rr_count", 32'(grants[i]), 32'd1);

        // Backpressure on a SUB while requester 3 waits.
        send(1, 32'd5, 32'd5, 4'd6);
        set_slice(3, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0);
        req_valid[3] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("bp_valid", 32'(rsp_valid), 32'd1);
            check("bp_z",     rsp_z, 32'd0);
            check("bp_zero",  32'(rsp_zero), 32'd1);
            check("bp_equal", 32'(rsp_equal), 32'd1);
            check("bp_ready", 32'(req_ready), 32'd0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        @(negedge clk);
        check("bp_released", 32'(rsp_valid), 32'd0);
        check("bp_next_grant", 32'(req_ready), 32'b1000);
        send(3, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0);
        expect_rsp("and", 3, 32'hF000_F000, 1'b0, 1'b0, 1'b0, 1'b0);

        // Directed op table, including illegal codes.
        for (int v = 0; v < NV; v++) begin
            send(v_id[v], v_x[v], v_y[v], v_op[v]);
            expect_rsp($sformatf("vec%0d", v), v_id[v], v_z[v], v_ovf[v], v_eq[v],
                       v_zr[v], v_er[v]);
        end

        // Abort: reset while EXEC; the result must never appear.
        send(1, 32'd4, 32'd4, 4'd5);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (rsp_valid) seen++;
        end
        check("abort_no_rsp", 32'(seen), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_rsp_z", rsp_z, 32'd0);
        req_valid = 4'b1111;
        #1;
        check("abort_ptr_zero", 32'(req_ready), 32'b0001);
        req_valid = '0;
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
